// File: rtl/arm_pkg.sv
// ARM integer datapath shared types and register-index constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package arm_pkg;

    typedef logic [31:0] word_t;
    typedef logic [3:0]  reg_addr_t;

    // R14 is the link register written by BL; address 15 is the PC, which
    // has no storage here and is sourced from fetch as PC+8.
    localparam reg_addr_t LR_IDX  = 4'd14;
    localparam reg_addr_t PC_IDX  = 4'd15;
    localparam int        NUM_GPR = 15;

endpackage

// File: rtl/register_write_decode.sv
// Write-port decode: result/link write requests -> per-register enables and data select.
// Latency: purely combinational.
// Backpressure: none; every request is decoded in the cycle it is presented.
//
// Ports:
//   we3     result write enable
//   a4      result write address (Rd)
//   we_lr   link write enable (targets R14)
//   wen     one-hot-per-register write enables, R0..R(NREGS-1)
//   sel_lr  per-register data select: 1 = take wd_lr, 0 = take wd3
module register_write_decode
    import arm_pkg::*;
#(
    parameter int NREGS = NUM_GPR
) (
    input  logic             we3,
    input  reg_addr_t        a4,
    input  logic             we_lr,
    output logic [NREGS-1:0] wen,
    output logic [NREGS-1:0] sel_lr
);

    always_comb begin
        wen    = '0;
        sel_lr = '0;
        // Only indices 0..NREGS-1 are compared, so a result write aimed at
        // the PC (address 15) matches nothing and is dropped here.
        for (int i = 0; i < NREGS; i++) begin
            if (we3 && (a4 == reg_addr_t'(i))) begin
                wen[i] = 1'b1;
            end
        end
        // Applied after the result decode so the link port overrides a
        // simultaneous result write to R14.
        if (we_lr) begin
            wen[LR_IDX]    = 1'b1;
            sel_lr[LR_IDX] = 1'b1;
        end
    end

endmodule

// File: rtl/register_file.sv
// ARM register file R0..R14 with three combinational read ports; address 15 returns PC+8 from fetch.
// Latency: reads zero-cycle combinational; writes visible after the next rising clk edge.
// Backpressure: none; writes always accepted (PC-targeted result writes are silently dropped).
//
// Optional feature macro: REGISTER_FILE_BYPASS_EN
//   defined   -> read ports forward same-cycle write data (link write has priority on R14)
//   undefined -> read ports return stored contents only
//
// Ports:
//   clk, reset       rising-edge clock; asynchronous active-high reset clears R0..R14
//   we3, a4, wd3     result write (Rd)
//   we_lr, wd_lr     link write into R14
//   a1, a2, a3       read addresses (Rn, Rm, Rs)
//   r15              PC+8 from fetch, returned for address 15
//   rd1, rd2, rd3    read data
module register_file
    import arm_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NREGS = NUM_GPR
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we3,
    input  reg_addr_t        a1,
    input  reg_addr_t        a2,
    input  reg_addr_t        a3,
    input  reg_addr_t        a4,
    input  logic [WIDTH-1:0] wd3,
    input  logic             we_lr,
    input  logic [WIDTH-1:0] wd_lr,
    input  logic [WIDTH-1:0] r15,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2,
    output logic [WIDTH-1:0] rd3
);

    logic [WIDTH-1:0] regs [NREGS];
    logic [NREGS-1:0] wen;
    logic [NREGS-1:0] sel_lr;

    register_write_decode #(
        .NREGS (NREGS)
    ) u_write_decode (
        .we3    (we3),
        .a4     (a4),
        .we_lr  (we_lr),
        .wen    (wen),
        .sel_lr (sel_lr)
    );

    // Storage. Reset is asynchronous and dominates any pending write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (wen[i]) begin
                    regs[i] <= sel_lr[i] ? wd_lr : wd3;
                end
            end
        end
    end

    // Read ports share one lookup so bypass rules stay identical across them.
    reg_addr_t        raddr [3];
    logic [WIDTH-1:0] rdata [3];

    assign raddr[0] = a1;
    assign raddr[1] = a2;
    assign raddr[2] = a3;

    always_comb begin
        for (int p = 0; p < 3; p++) begin
            rdata[p] = (raddr[p] == PC_IDX) ? r15 : regs[raddr[p]];
`ifdef REGISTER_FILE_BYPASS_EN
            // Link checked first: it also wins the R14 write at the edge.
            if (we_lr && (raddr[p] == LR_IDX)) begin
                rdata[p] = wd_lr;
            end else if (we3 && (a4 != PC_IDX) && (raddr[p] == a4)) begin
                rdata[p] = wd3;
            end
`endif
        end
    end

    assign rd1 = rdata[0];
    assign rd2 = rdata[1];
    assign rd3 = rdata[2];

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: stimulus pushes expected read data, monitor compares on negedge.
// Latency: n/a (testbench).
// Backpressure: n/a.
module tb_register_file;
    import arm_pkg::*;

    logic        clk;
    logic        reset;
    logic        we3;
    reg_addr_t   a1, a2, a3, a4;
    logic [31:0] wd3;
    logic        we_lr;
    logic [31:0] wd_lr;
    logic [31:0] r15;
    logic [31:0] rd1, rd2, rd3;

    register_file #(
        .WIDTH (32),
        .NREGS (15)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .we3   (we3),
        .a1    (a1),
        .a2    (a2),
        .a3    (a3),
        .a4    (a4),
        .wd3   (wd3),
        .we_lr (we_lr),
        .wd_lr (wd_lr),
        .r15   (r15),
        .rd1   (rd1),
        .rd2   (rd2),
        .rd3   (rd3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] e1;
        logic [31:0] e2;
        logic [31:0] e3;
        logic [2:0]  mask;   // bit0 rd1, bit1 rd2, bit2 rd3
    } exp_t;

    exp_t sb [$];
    exp_t cur;
    logic chk_vld;
    logic done;
    int   checks;
    int   errors;

`ifdef REGISTER_FILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    // Monitor: sole owner of the counters.
    always @(negedge clk) begin
        if (chk_vld) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_underflow: got sample with empty queue, required pending entry");
            end else begin
                cur = sb.pop_front();
                if (cur.mask[0]) begin
                    if (rd1 !== cur.e1) begin
                        errors++;
                        $display("FAIL %s rd1: got %h, required %h", cur.name, rd1, cur.e1);
                    end
                end
                if (cur.mask[1]) begin
                    checks++;
                    if (rd2 !== cur.e2) begin
                        errors++;
                        $display("FAIL %s rd2: got %h, required %h", cur.name, rd2, cur.e2);
                    end
                end
                if (cur.mask[2]) begin
                    checks++;
                    if (rd3 !== cur.e3) begin
                        errors++;
                        $display("FAIL %s rd3: got %h, required %h", cur.name, rd3, cur.e3);
                    end
                end
            end
        end else if (done) begin
            checks++;
            if (sb.size() != 0) begin
                errors++;
                $display("FAIL scoreboard_drain: got %0d entries left, required 0", sb.size());
            end
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got no completion by 20000, required completion");
        $fatal(1, "watchdog expired");
    end

    // Call between posedge and negedge; the monitor samples at the next negedge.
    task automatic expect3(input string name, input logic [31:0] e1, input logic [31:0] e2,
                           input logic [31:0] e3, input logic [2:0] mask);
        exp_t e;
        e.name = name; e.e1 = e1; e.e2 = e2; e.e3 = e3; e.mask = mask;
        sb.push_back(e);
        chk_vld = 1'b1;
        @(negedge clk);
        #1;
        chk_vld = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_addr(input reg_addr_t x1, input reg_addr_t x2, input reg_addr_t x3);
        a1 = x1; a2 = x2; a3 = x3;
    endtask

    task automatic wr(input logic w3, input reg_addr_t ad, input logic [31:0] d3,
                      input logic wl, input logic [31:0] dl);
        we3 = w3; a4 = ad; wd3 = d3; we_lr = wl; wd_lr = dl;
    endtask

    initial begin
        chk_vld = 1'b0;
        done    = 1'b0;
        checks  = 0;
        errors  = 0;
        reset   = 1'b1;
        r15     = 32'h0000_0108;
        wr(1'b0, 4'd0, 32'h0, 1'b0, 32'h0);
        rd_addr(4'd0, 4'd7, 4'd14);
        tick();

        // 1: reset state, PC read
        expect3("reset_regs", 32'h0, 32'h0, 32'h0, 3'b111);
        tick();
        rd_addr(4'd15, 4'd1, 4'd2);
        expect3("reset_pc", 32'h108, 32'h0, 32'h0, 3'b111);
        reset = 1'b0;

        // 2: write/read
        wr(1'b1, 4'd3, 32'hDEAD_BEEF, 1'b0, 32'h0);
        tick();
        wr(1'b0, 4'd0, 32'h0, 1'b0, 32'h0);
        rd_addr(4'd0, 4'd3, 4'd4);
        expect3("write_r3", 32'h0, 32'hDEAD_BEEF, 32'h0, 3'b111);

        // 3: PC-targeted write dropped
        wr(1'b1, 4'd15, 32'h1234, 1'b0, 32'h0);
        tick();
        wr(1'b0, 4'd0, 32'h0, 1'b0, 32'h0);
        rd_addr(4'd15, 4'd3, 4'd0);
        expect3("pc_write_drop", 32'h108, 32'hDEAD_BEEF, 32'h0, 3'b111);
        tick();
        rd_addr(4'd14, 4'd1, 4'd2);
        expect3("pc_write_regs", 32'h0, 32'h0, 32'h0, 3'b111);

        // 4: link collision on R14, then parallel writes
        wr(1'b1, 4'd14, 32'hAAAA_AAAA, 1'b1, 32'h0000_0040);
        tick();
        wr(1'b0, 4'd0, 32'h0, 1'b0, 32'h0);
        rd_addr(4'd14, 4'd3, 4'd0);
        expect3("lr_collision", 32'h40, 32'hDEAD_BEEF, 32'h0, 3'b111);
        wr(1'b1, 4'd14, 32'h0, 1'b0, 32'h0);
        tick();
        wr(1'b0, 4'd0, 32'h0, 1'b0, 32'h0);
        rd_addr(4'd14, 4'd5, 4'd3);
        expect3("r14_clear", 32'h0, 32'h0, 32'hDEAD_BEEF, 3'b111);
        wr(1'b1, 4'd5, 32'hAAAA_AAAA, 1'b1, 32'h0000_0040);
        tick();
        wr(1'b0, 4'd0, 32'h0, 1'b0, 32'h0);
        rd_addr(4'd5, 4'd14, 4'd3);
        expect3("dual_write", 32'hAAAA_AAAA, 32'h40, 32'hDEAD_BEEF, 3'b111);

        // 5: asynchronous reset between edges, write held during reset
        wr(1'b1, 4'd1, 32'h11, 1'b0, 32'h0);
        tick();
        wr(1'b0, 4'd0, 32'h0, 1'b0, 32'h0);
        rd_addr(4'd1, 4'd5, 4'd14);
        expect3("fill_r1", 32'h11, 32'hAAAA_AAAA, 32'h40, 3'b111);
        @(posedge clk);
        #2;
        reset = 1'b1;
        wr(1'b1, 4'd6, 32'h99, 1'b0, 32'h0);
        rd_addr(4'd1, 4'd5, 4'd15);
        expect3("async_reset", 32'h0, 32'h0, 32'h108, 3'b111);
        tick();
        rd_addr(4'd1, 4'd14, 4'd3);
        expect3("reset_held_write", 32'h0, 32'h0, 32'h0, 3'b111);
        tick();
        reset = 1'b0;
        rd_addr(4'd6, 4'd5, 4'd3);
        expect3("reset_release", BYP ? 32'h99 : 32'h0, 32'h0, 32'h0, 3'b111);
        tick();
        wr(1'b0, 4'd0, 32'h0, 1'b0, 32'h0);
        expect3("post_reset_write", 32'h99, 32'h0, 32'h0, 3'b111);

        // 6: same-cycle forwarding (bypass build) vs stored value
        wr(1'b1, 4'd2, 32'h22, 1'b0, 32'h0);
        tick();
        wr(1'b1, 4'd2, 32'h55, 1'b0, 32'h0);
        rd_addr(4'd2, 4'd0, 4'd15);
        expect3("bypass_wd3", BYP ? 32'h55 : 32'h22, 32'h0, 32'h108, 3'b111);
        tick();
        wr(1'b0, 4'd0, 32'h0, 1'b0, 32'h0);
        expect3("after_edge_wd3", 32'h55, 32'h0, 32'h108, 3'b111);
        tick();
        wr(1'b1, 4'd14, 32'h77, 1'b1, 32'h200);
        rd_addr(4'd2, 4'd14, 4'd14);
        expect3("bypass_lr", 32'h55, BYP ? 32'h200 : 32'h0, BYP ? 32'h200 : 32'h0, 3'b111);
        tick();
        wr(1'b0, 4'd0, 32'h0, 1'b0, 32'h0);
        expect3("after_edge_lr", 32'h55, 32'h200, 32'h200, 3'b111);

        done = 1'b1;
    end

endmodule
